// File: rtl/subprog_pkg.sv
// Shared encodings for the subprogram call/return convention.
package subprog_pkg;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Subtracting calls run as A + ~B + 1 and report an inverted carry as borrow.
    function automatic logic is_sub(input logic [1:0] op);
        return (op == OP_DEC) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder used as the single arithmetic cell of the serial datapath.
module serial_fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/subprog_call_responder.sv
// Callee that evaluates INC/DEC/ADD/SUB calls bit-serially, LSB first,
// and returns the result over a valid/ready response channel.
module subprog_call_responder
    import subprog_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             sub_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_carry_q;

    logic             sum_c;
    logic             cout_c;
    logic             last_step_c;
    logic [WIDTH-1:0] b_sel_c;
    logic [WIDTH-1:0] res_next_c;

    serial_fa_bit u_fa (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .s_o    (sum_c),
        .cout_o (cout_c)
    );

    // INC/DEC use an implicit second operand of one.
    assign b_sel_c     = req_op[1] ? req_b : WIDTH'(1);
    assign last_step_c = (cnt_q == CW'(WIDTH - 1));
    assign res_next_c  = {sum_c, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            sub_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid) begin
                        a_q         <= req_a;
                        b_q         <= is_sub(req_op) ? ~b_sel_c : b_sel_c;
                        carry_q     <= is_sub(req_op);
                        sub_q       <= is_sub(req_op);
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_next_c;
                    carry_q <= cout_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_step_c) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= res_next_c;
                        rsp_carry_q  <= cout_c ^ sub_q;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;

endmodule

// File: tb/tb_subprog_call_responder.sv
// Scoreboard bench: driver pushes expected results computed arithmetically,
// monitor pops and checks them, including response latency and hold behaviour.
module tb_subprog_call_responder;

    localparam int unsigned WIDTH = 8;
    localparam longint      LAT   = 8;

    typedef struct {
        int     res;
        int     cy;
        longint acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;

    exp_t   exp_q[$];
    longint cyc = 0;
    int     errors = 0;
    int     checks = 0;
    int     rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    bit     shown = 1'b0;
    int     held_res = 0;
    int     held_cy = 0;

    subprog_call_responder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial rsp_ready = 1'b1;
    always @(negedge clk) begin
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain modular arithmetic on integers.
    function automatic exp_t model(input logic [1:0] op, input int a, input int b, input longint acc);
        exp_t m;
        int r;
        case (op)
            2'b00:   r = a + 1;
            2'b01:   r = a - 1;
            2'b10:   r = a + b;
            default: r = a - b;
        endcase
        m.res = r & 255;
        m.cy  = ((r > 255) || (r < 0)) ? 1 : 0;
        m.acc = acc;
        return m;
    endfunction

    task automatic call(input logic [1:0] op, input int a, input int b);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = WIDTH'(a);
        req_b     = WIDTH'(b);
        @(posedge clk);
        #1;
        exp_q.push_back(model(op, a, b, cyc));
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: latency, value, hold and handshake checks against the scoreboard.
    always @(posedge clk) begin
        logic hs;
        hs = rsp_valid && rsp_ready;
        #1;
        if (!rst_n) begin
            shown = 1'b0;
        end else if (exp_q.size() == 0) begin
            shown = 1'b0;
            chk("no_spurious_rsp", rsp_valid, 0);
        end else if (!shown) begin
            if (rsp_valid) begin
                chk("rsp_latency", cyc - exp_q[0].acc, LAT);
                chk("rsp_result", rsp_result, exp_q[0].res);
                chk("rsp_carry", rsp_carry, exp_q[0].cy);
                held_res = rsp_result;
                held_cy  = rsp_carry;
                shown    = 1'b1;
            end else if (cyc - exp_q[0].acc >= LAT) begin
                chk("rsp_late", cyc - exp_q[0].acc, LAT - 1);
                void'(exp_q.pop_front());
            end else begin
                chk("req_ready_exec", req_ready, 0);
            end
        end else if (hs) begin
            chk("valid_drop", rsp_valid, 0);
            void'(exp_q.pop_front());
            shown = 1'b0;
        end else begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, held_res);
            chk("hold_carry", rsp_carry, held_cy);
            chk("req_ready_done", req_ready, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        rst_n = 1'b1;

        // Directed calls including wrap-around cases
        call(2'b00, 0, 0);
        call(2'b00, 6, 0);
        call(2'b10, 7, 4);
        call(2'b10, 200, 100);
        call(2'b00, 255, 0);
        call(2'b11, 4, 7);
        call(2'b11, 7, 4);
        call(2'b01, 0, 0);
        wait_idle();

        // Back-pressure plus a request pulse that must be ignored during EXEC
        rdy_mode = 0;
        @(negedge clk);
        call(2'b10, 3, 5);
        repeat (3) @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_a     = WIDTH'(1);
        req_b     = WIDTH'(2);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", rsp_valid, 1);
        repeat (5) @(negedge clk);
        rdy_mode = 1;
        wait_idle();

        // Randomized calls with random response back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            call(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        rdy_mode = 1;
        wait_idle();

        // Reset during EXEC aborts the call
        call(2'b10, 9, 9);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_result", rsp_result, 0);
        chk("abort_rsp_carry", rsp_carry, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        call(2'b10, 1, 1);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
